// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the block-serial multiplier arbiter
// and its round-robin picker.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD        = 2'd1,
    WAIT_RESULT = 2'd2,
    DRAIN       = 2'd3
  } mult_arb_state_t;

  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_BITS_IN_NUM   = 4096;
  localparam int DEF_BLOCKS        = DEF_BITS_IN_NUM / DEF_REGISTER_SIZE;

  function automatic int calc_blocks(input int bits_in_num, input int register_size);
    return bits_in_num / register_size;
  endfunction

  function automatic int calc_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting index at or
// after rr_ptr, wrapping around.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 2,
  localparam int ID_WIDTH = calc_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   first_off;
  int                   sum;

  always_comb begin
    req_dbl   = {req, req} >> rr_ptr;
    req_rot   = req_dbl[NUM_REQ-1:0];
    first_off = 0;
    // Scan downwards so the lowest rotated offset is the last one written.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_rot[off]) first_off = off;
    end
    sum = int'(rr_ptr) + first_off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant_id    = ID_WIDTH'(sum);
    grant_valid = |req;
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one block-serial multiplier among NUM_REQ requesters: grants one job
// at a time, streams its operand blocks in and routes the product blocks back.
module multiplier_arbiter
  import mult_arb_pkg::*;
#(
  parameter int  NUM_REQ       = 2,
  parameter int  REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int  BITS_IN_NUM   = DEF_BITS_IN_NUM,
  localparam int BLOCKS        = calc_blocks(BITS_IN_NUM, REGISTER_SIZE),
  localparam int ID_WIDTH      = calc_id_width(NUM_REQ)
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  input  logic [NUM_REQ-1:0][REGISTER_SIZE-1:0]  req_n_in,
  input  logic [NUM_REQ-1:0][REGISTER_SIZE-1:0]  req_m_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  output logic [REGISTER_SIZE-1:0]               resp_data_out,
  output logic [NUM_REQ-1:0]                     resp_valid_out,
  output logic                                   resp_final_out,
  output logic [ID_WIDTH-1:0]                    owner_id_out,
  output logic                                   busy_out,
  output logic [REGISTER_SIZE-1:0]               mult_n_out,
  output logic [REGISTER_SIZE-1:0]               mult_m_out,
  output logic                                   mult_valid_out,
  input  logic                                   mult_ready_in,
  input  logic [REGISTER_SIZE-1:0]               mult_data_in,
  input  logic                                   mult_valid_in,
  input  logic                                   mult_final_in
);

  localparam int CNT_W = $clog2(BLOCKS + 1);

  mult_arb_state_t      state, state_nxt;
  logic [ID_WIDTH-1:0]  owner, rr_ptr, grant_id;
  logic                 grant_valid;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 load_open, xfer, fwd, job_done, grant;
  logic [NUM_REQ-1:0]   owner_onehot;

  logic [REGISTER_SIZE-1:0] mult_n_p1, mult_m_p1, resp_data_p1;
  logic                     mult_vld_p1, resp_final_p1;
  logic [NUM_REQ-1:0]       resp_vld_p1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req         (req_valid_in),
    .rr_ptr      (rr_ptr),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign grant        = (state == IDLE) && grant_valid && mult_ready_in;
  assign load_open    = (state == LOAD) && (beat_cnt < CNT_W'(BLOCKS));
  assign xfer         = load_open && req_valid_in[owner];
  assign fwd          = ((state == WAIT_RESULT) || (state == DRAIN)) && mult_valid_in;
  assign job_done     = fwd && mult_final_in;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  always_comb begin
    req_ready_out = '0;
    if (load_open) req_ready_out = owner_onehot;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (grant) state_nxt = LOAD;
      LOAD:        if (xfer && (beat_cnt == CNT_W'(BLOCKS - 1))) state_nxt = WAIT_RESULT;
      WAIT_RESULT: if (fwd) state_nxt = job_done ? IDLE : DRAIN;
      DRAIN:       if (job_done) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= grant_id;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (job_done) rr_ptr <= (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  // p1: operand beats toward the multiplier, product beats back to the owner
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mult_n_p1     <= '0;
      mult_m_p1     <= '0;
      mult_vld_p1   <= 1'b0;
      resp_data_p1  <= '0;
      resp_vld_p1   <= '0;
      resp_final_p1 <= 1'b0;
    end else begin
      mult_vld_p1 <= xfer;
      if (xfer) begin
        mult_n_p1 <= req_n_in[owner];
        mult_m_p1 <= req_m_in[owner];
      end
      resp_data_p1  <= fwd ? mult_data_in : '0;
      resp_vld_p1   <= fwd ? owner_onehot : '0;
      resp_final_p1 <= job_done;
    end
  end

  assign mult_n_out     = mult_n_p1;
  assign mult_m_out     = mult_m_p1;
  assign mult_valid_out = mult_vld_p1;
  assign resp_data_out  = resp_data_p1;
  assign resp_valid_out = resp_vld_p1;
  assign resp_final_out = resp_final_p1;
  assign owner_id_out   = owner;
  assign busy_out       = (state != IDLE);

endmodule
